// File: rtl/enemy_patrol_engine_if.sv
// Player inputs and enemy/game status outputs of the patrol engine.
// The engine drives the slave side; the game logic or bench drives the master side.
interface enemy_patrol_engine_if #(
    parameter int NUM_ENEMIES = 4,
    parameter int COORD_W     = 10
);
    logic                           frame_tick;
    logic                           start_button;
    logic [COORD_W-1:0]             mario_x;
    logic [COORD_W-1:0]             mario_y;
    logic                           mario_falling;
    logic [NUM_ENEMIES*COORD_W-1:0] enemy_x;
    logic [NUM_ENEMIES*COORD_W-1:0] enemy_y;
    logic [NUM_ENEMIES-1:0]         enemy_alive;
    logic [3:0]                     lives;
    logic [7:0]                     score;
    logic                           invulnerable;
    logic                           game_over;
    logic                           busy;
    logic [1:0]                     state;

    modport master (
        output frame_tick, start_button, mario_x, mario_y, mario_falling,
        input  enemy_x, enemy_y, enemy_alive, lives, score, invulnerable,
               game_over, busy, state
    );

    modport slave (
        input  frame_tick, start_button, mario_x, mario_y, mario_falling,
        output enemy_x, enemy_y, enemy_alive, lives, score, invulnerable,
               game_over, busy, state
    );
endinterface

// File: rtl/enemy_patrol_engine.sv
// Enemy patrol, collision, lives/score engine; one enemy scanned per cycle after each frame_tick.
// Latency: enemy i updated at end of cycle t+1+i; game state settles the cycle after the scan.
// Backpressure: none; frame_tick arriving while busy is dropped, never queued.
module enemy_patrol_engine #(
    parameter int NUM_ENEMIES     = 4,
    parameter int COORD_W         = 10,
    parameter int CHARACTER_WIDTH = 42,
    parameter int SCREEN_WIDTH    = 640,
    parameter int SPAWN_BASE      = 200,
    parameter int SPAWN_STEP      = 100,
    parameter int GROUND_Y        = 398,
    parameter int SPEED           = 2,
    parameter int START_LIVES     = 3,
    parameter int INVULN_FRAMES   = 60,
    parameter int STOMP_MARGIN    = 8
) (
    input logic                  vga_clock,
    input logic                  reset,
    enemy_patrol_engine_if.slave bus
);
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_PLAYING   = 2'd1;
    localparam logic [1:0] ST_GAME_OVER = 2'd2;

    localparam int CW1   = COORD_W + 1;
    localparam int IDX_W = (NUM_ENEMIES > 1) ? $clog2(NUM_ENEMIES) : 1;
    localparam int INV_W = (INVULN_FRAMES < 1) ? 1 : $clog2(INVULN_FRAMES + 1);

    localparam logic [CW1-1:0] SIZE_C   = CW1'(CHARACTER_WIDTH);
    localparam logic [CW1-1:0] MAX_X_C  = CW1'(SCREEN_WIDTH - CHARACTER_WIDTH);
    localparam logic [CW1-1:0] SPEED_C  = CW1'(SPEED);
    localparam logic [CW1-1:0] MARGIN_C = CW1'(STOMP_MARGIN);

    logic [COORD_W-1:0]     ex [NUM_ENEMIES];
    logic [COORD_W-1:0]     ey [NUM_ENEMIES];
    logic [NUM_ENEMIES-1:0] alive;
    logic [NUM_ENEMIES-1:0] dir_left;
    logic [1:0]             state;
    logic [3:0]             lives;
    logic [7:0]             score;
    logic [INV_W-1:0]       inv_cnt;
    logic                   busy;
    logic [IDX_W-1:0]       idx;
    logic                   hit_done;

    logic [CW1-1:0]         cur_x, cur_y, mx, my, dx, dy, sum, diff;
    logic                   overlap, do_stomp, do_hit, last_enemy;
    logic [COORD_W-1:0]     nx;
    logic                   nleft;
    logic [3:0]             lives_nxt;
    logic [NUM_ENEMIES-1:0] alive_nxt;

    // Processing of the enemy currently addressed by the scan index.
    always_comb begin
        cur_x      = {1'b0, ex[idx]};
        cur_y      = {1'b0, ey[idx]};
        mx         = {1'b0, bus.mario_x};
        my         = {1'b0, bus.mario_y};
        dx         = (mx >= cur_x) ? (mx - cur_x) : (cur_x - mx);
        dy         = (my >= cur_y) ? (my - cur_y) : (cur_y - my);
        overlap    = alive[idx] && (dx < SIZE_C) && (dy < SIZE_C);
        do_stomp   = overlap && bus.mario_falling && ((my + SIZE_C) <= (cur_y + MARGIN_C));
        do_hit     = overlap && !do_stomp && (inv_cnt == '0) && !hit_done;
        sum        = cur_x + SPEED_C;
        diff       = cur_x - SPEED_C;
        nx         = ex[idx];
        nleft      = dir_left[idx];
        if (!dir_left[idx]) begin
            if (sum >= MAX_X_C) begin
                nx    = MAX_X_C[COORD_W-1:0];
                nleft = 1'b1;
            end else begin
                nx    = sum[COORD_W-1:0];
            end
        end else begin
            if (cur_x <= SPEED_C) begin
                nx    = '0;
                nleft = 1'b0;
            end else begin
                nx    = diff[COORD_W-1:0];
            end
        end
        lives_nxt  = (do_hit && lives != 4'd0) ? (lives - 4'd1) : lives;
        alive_nxt  = alive;
        if (do_stomp) alive_nxt[idx] = 1'b0;
        last_enemy = (idx == IDX_W'(NUM_ENEMIES - 1));
    end

    always_ff @(posedge vga_clock) begin
        if (!reset) begin
            state    <= ST_IDLE;
            lives    <= 4'(START_LIVES);
            score    <= '0;
            inv_cnt  <= '0;
            busy     <= 1'b0;
            idx      <= '0;
            hit_done <= 1'b0;
            alive    <= '1;
            dir_left <= '0;
            for (int i = 0; i < NUM_ENEMIES; i++) begin
                ex[i] <= COORD_W'(SPAWN_BASE + i * SPAWN_STEP);
                ey[i] <= COORD_W'(GROUND_Y);
            end
        end else begin
            case (state)
                ST_PLAYING: begin
                    if (busy) begin
                        if (alive[idx]) begin
                            if (do_stomp) begin
                                score <= (score == 8'hFF) ? score : (score + 8'd1);
                            end else begin
                                ex[idx]       <= nx;
                                dir_left[idx] <= nleft;
                            end
                            if (do_hit) begin
                                lives    <= lives_nxt;
                                inv_cnt  <= INV_W'(INVULN_FRAMES);
                                hit_done <= 1'b1;
                            end
                        end
                        alive <= alive_nxt;
                        if (last_enemy) begin
                            busy <= 1'b0;
                            if (lives_nxt == 4'd0) begin
                                state <= ST_GAME_OVER;
                            end else if (alive_nxt == '0) begin
                                // Wave cleared: fresh wave, score and lives carry over.
                                alive    <= '1;
                                dir_left <= '0;
                                for (int i = 0; i < NUM_ENEMIES; i++) begin
                                    ex[i] <= COORD_W'(SPAWN_BASE + i * SPAWN_STEP);
                                    ey[i] <= COORD_W'(GROUND_Y);
                                end
                            end
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else if (bus.frame_tick) begin
                        busy     <= 1'b1;
                        idx      <= '0;
                        hit_done <= 1'b0;
                        if (inv_cnt != '0) inv_cnt <= inv_cnt - 1'b1;
                    end
                end
                default: begin
                    // IDLE, GAME_OVER and the unused encoding all wait for start.
                    if (bus.start_button) begin
                        state    <= ST_PLAYING;
                        lives    <= 4'(START_LIVES);
                        score    <= '0;
                        inv_cnt  <= '0;
                        busy     <= 1'b0;
                        idx      <= '0;
                        hit_done <= 1'b0;
                        alive    <= '1;
                        dir_left <= '0;
                        for (int i = 0; i < NUM_ENEMIES; i++) begin
                            ex[i] <= COORD_W'(SPAWN_BASE + i * SPAWN_STEP);
                            ey[i] <= COORD_W'(GROUND_Y);
                        end
                    end
                end
            endcase
        end
    end

    for (genvar g = 0; g < NUM_ENEMIES; g++) begin : g_pack
        assign bus.enemy_x[g*COORD_W +: COORD_W] = ex[g];
        assign bus.enemy_y[g*COORD_W +: COORD_W] = ey[g];
    end

    assign bus.enemy_alive  = alive;
    assign bus.lives        = lives;
    assign bus.score        = score;
    assign bus.invulnerable = (inv_cnt != '0);
    assign bus.game_over    = (state == ST_GAME_OVER);
    assign bus.busy         = busy;
    assign bus.state        = state;
endmodule
